// File: rtl/l2_bank_rr_arbiter.sv
// l2_bank_rr_arbiter: round-robin arbiter sharing one L2 bank among NumPorts requesters,
// returning a one-cycle-late response (read data or write ack) to the granted port.
module l2_bank_rr_arbiter #(
   parameter  int NumPorts  = 4,
   parameter  int NumWords  = 4096,
   parameter  int DataWidth = 32,
   localparam int AddrWidth = $clog2(NumWords),
   localparam int BeWidth   = DataWidth / 8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumPorts-1:0]                 req_i,
   input  logic [NumPorts-1:0]                 we_i,
   input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
   input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
   output logic [NumPorts-1:0]                 gnt_o,
   output logic [NumPorts-1:0]                 rvalid_o,
   output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
   output logic                                bank_req_o,
   output logic                                bank_we_o,
   output logic [AddrWidth-1:0]                bank_addr_o,
   output logic [DataWidth-1:0]                bank_wdata_o,
   output logic [BeWidth-1:0]                  bank_be_o,
   input  logic [DataWidth-1:0]                bank_rdata_i
);
   localparam int PtrWidth = NumPorts > 1 ? $clog2(NumPorts) : 1;
   logic [PtrWidth-1:0] r_ptr, r_resp_port, w_idx;
   logic                r_resp_valid, w_any;
   logic [NumPorts-1:0] w_gnt;
   int                  w_j;
   // Scan ports in cyclic order starting at r_ptr; the first requester wins.
   always_comb begin
      w_idx = '0;
      w_any = 1'b0;
      w_gnt = '0;
      w_j   = 0;
      for (int i = 0; i < NumPorts; i++) begin
         w_j = (int'(r_ptr) + i) % NumPorts;
         if (!rst_i && !w_any && req_i[w_j]) begin
            w_any      = 1'b1;
            w_idx      = PtrWidth'(w_j);
            w_gnt[w_j] = 1'b1;
         end
      end
   end
   assign gnt_o        = w_gnt;
   assign bank_req_o   = w_any;
   assign bank_we_o    = w_any & we_i[w_idx];
   assign bank_addr_o  = addr_i[w_idx];
   assign bank_wdata_o = wdata_i[w_idx];
   assign bank_be_o    = be_i[w_idx];
   assign rdata_o      = {NumPorts{bank_rdata_i}};
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_port  <= '0;
      end else begin
         r_resp_valid <= w_any;
         if (w_any) begin
            r_resp_port <= w_idx;
            r_ptr       <= (int'(w_idx) == NumPorts - 1) ? '0 : w_idx + 1'b1;
         end
      end
   end
   // A response due during reset is suppressed so no stale rvalid escapes.
   always_comb begin
      rvalid_o = '0;
      if (r_resp_valid && !rst_i) rvalid_o[r_resp_port] = 1'b1;
   end
endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// tb_l2_bank_rr_arbiter: scoreboard bench; a cyclic-priority reference model predicts grants
// and responses, a separate monitor checks rvalid/rdata one cycle later.
module tb_l2_bank_rr_arbiter;
   localparam int P = 4, W = 4096, D = 32, A = 12, B = 4;
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;
   logic [P-1:0]        req_i, we_i, gnt_o, rvalid_o;
   logic [P-1:0][A-1:0] addr_i;
   logic [P-1:0][D-1:0] wdata_i, rdata_o;
   logic [P-1:0][B-1:0] be_i;
   logic                bank_req_o, bank_we_o;
   logic [A-1:0]        bank_addr_o;
   logic [D-1:0]        bank_wdata_o, bank_rdata_i;
   logic [B-1:0]        bank_be_o;
   l2_bank_rr_arbiter u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
      .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i));
   logic              req1, we1, gnt1, rv1, b_req1, b_we1;
   logic [0:0][A-1:0] addr1;
   logic [A-1:0]      b_addr1;
   logic [0:0][D-1:0] wdata1, rdata1;
   logic [D-1:0]      b_wdata1;
   logic [0:0][B-1:0] be1;
   logic [B-1:0]      b_be1;
   assign we1 = 1'b0;
   assign addr1 = '0;
   assign wdata1 = '0;
   assign be1 = '0;
   l2_bank_rr_arbiter #(.NumPorts(1)) u_one (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req1), .we_i(we1), .addr_i(addr1),
      .wdata_i(wdata1), .be_i(be1), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rdata1),
      .bank_req_o(b_req1), .bank_we_o(b_we1), .bank_addr_o(b_addr1),
      .bank_wdata_o(b_wdata1), .bank_be_o(b_be1), .bank_rdata_i(32'h0));
   // Bank environment: synchronous memory driven only by the DUT's bank port.
   logic [D-1:0] bank_mem [W];
   always @(posedge clk_i) begin
      if (bank_req_o) begin
         if (bank_we_o) begin
            for (int b = 0; b < B; b++)
               if (bank_be_o[b]) bank_mem[bank_addr_o][8*b +: 8] <= bank_wdata_o[8*b +: 8];
         end else begin
            bank_rdata_i <= bank_mem[bank_addr_o];
         end
      end
   end
   // Reference model state
   logic [D-1:0] ref_mem [W];
   bit           p_req [P];
   bit           p_we [P];
   logic [A-1:0] p_addr [P];
   logic [D-1:0] p_wdata [P];
   logic [B-1:0] p_be [P];
   int           m_ptr = 0, cyc = 0, total = 0, bad = 0;
   bit           last1 = 1'b0;
   typedef struct {int cyc; int port; bit rd; logic [D-1:0] data;} exp_t;
   exp_t q[$];
   always @(posedge clk_i) cyc <= cyc + 1;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask
   task automatic set(int p, bit we, logic [A-1:0] a, logic [D-1:0] d, logic [B-1:0] be);
      p_req[p] = 1'b1;
      p_we[p] = we;
      p_addr[p] = a;
      p_wdata[p] = d;
      p_be[p] = be;
   endtask
   task automatic tick();
      for (int k = 0; k < P; k++) begin
         req_i[k] = p_req[k];
         we_i[k] = p_we[k];
         addr_i[k] = p_addr[k];
         wdata_i[k] = p_wdata[k];
         be_i[k] = p_be[k];
      end
      @(posedge clk_i);
      #1;
   endtask
   // Model: predict this cycle's grant and bank drive, queue the response.
   always @(negedge clk_i) begin : model
      int w;
      bit any;
      logic [P-1:0] eg;
      exp_t e;
      w = -1;
      any = 1'b0;
      for (int k = 0; k < P; k++) any |= p_req[k];
      if (rst_i) begin
         chk("gnt_rst", 64'(gnt_o), 64'd0);
         chk("bank_req_rst", 64'(bank_req_o), 64'd0);
         chk("bank_we_rst", 64'(bank_we_o), 64'd0);
         m_ptr = 0;
      end else begin
         for (int i = 0; i < P; i++)
            if (w < 0 && p_req[(m_ptr + i) % P]) w = (m_ptr + i) % P;
         eg = '0;
         if (w >= 0) eg[w] = 1'b1;
         chk("gnt", 64'(gnt_o), 64'(eg));
         chk("bank_req", 64'(bank_req_o), 64'(any));
         if (w >= 0) begin
            chk("bank_we", 64'(bank_we_o), 64'(p_we[w]));
            chk("bank_addr", 64'(bank_addr_o), 64'(p_addr[w]));
            e.cyc = cyc;
            e.port = w;
            e.rd = !p_we[w];
            e.data = ref_mem[p_addr[w]];
            if (p_we[w]) begin
               chk("bank_wdata", 64'(bank_wdata_o), 64'(p_wdata[w]));
               chk("bank_be", 64'(bank_be_o), 64'(p_be[w]));
               for (int b = 0; b < B; b++)
                  if (p_be[w][b]) ref_mem[p_addr[w]][8*b +: 8] = p_wdata[w][8*b +: 8];
            end
            q.push_back(e);
            m_ptr = (w + 1) % P;
            p_req[w] = 1'b0;
         end else begin
            chk("bank_we_idle", 64'(bank_we_o), 64'd0);
         end
      end
   end
   // Monitor: a queued response is due the cycle after its grant.
   always @(negedge clk_i) begin : monitor
      logic [P-1:0] ev;
      exp_t e;
      ev = '0;
      if (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         if (!rst_i) begin
            ev[e.port] = 1'b1;
            if (e.rd) chk("rdata", 64'(rdata_o[e.port]), 64'(e.data));
         end
      end
      chk("rvalid", 64'(rvalid_o), 64'(ev));
   end
   always @(negedge clk_i) begin : single_port
      chk("gnt1", 64'(gnt1), rst_i ? 64'd0 : 64'(req1));
      chk("rvalid1", 64'(rv1), rst_i ? 64'd0 : 64'(last1));
      last1 = req1 && !rst_i;
   end
   initial begin
      for (int i = 0; i < W; i++) begin
         ref_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1234;
         bank_mem[i] = ref_mem[i];
      end
      ref_mem[5] = 32'hDEADBEEF;
      bank_mem[5] = 32'hDEADBEEF;
      ref_mem[7] = 32'hFFFFFFFF;
      bank_mem[7] = 32'hFFFFFFFF;
      for (int k = 0; k < P; k++) set(k, 1'b0, '0, '0, '0);
      for (int k = 0; k < P; k++) p_req[k] = 1'b0;
      rst_i = 1'b1;
      req1 = 1'b0;
      repeat (3) tick();
      rst_i = 1'b0;
      set(2, 1'b0, 12'd5, '0, '0);
      repeat (2) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      repeat (6) begin
         for (int k = 0; k < P; k++) if (!p_req[k]) set(k, 1'b0, A'(k), '0, '0);
         tick();
      end
      repeat (4) tick();
      set(1, 1'b1, 12'd7, 32'h12345678, 4'b0011);
      tick();
      set(1, 1'b0, 12'd7, '0, '0);
      repeat (2) tick();
      set(3, 1'b0, 12'd3, '0, '0);
      tick();
      set(0, 1'b0, 12'd0, '0, '0);
      set(3, 1'b0, 12'd9, '0, '0);
      repeat (3) tick();
      set(1, 1'b0, 12'd1, '0, '0);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      set(0, 1'b0, 12'd2, '0, '0);
      set(1, 1'b0, 12'd4, '0, '0);
      repeat (3) tick();
      req1 = 1'b1;
      repeat (3) tick();
      req1 = 1'b0;
      repeat (2) tick();
      repeat (3000) begin
         rst_i = ($urandom_range(99) == 0);
         for (int k = 0; k < P; k++)
            if (!p_req[k] && $urandom_range(2) == 0)
               set(k, 1'($urandom_range(1)), A'($urandom_range(15)), $urandom, B'($urandom));
         req1 = 1'($urandom_range(1));
         tick();
      end
      rst_i = 1'b0;
      req1 = 1'b0;
      repeat (10) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
